// File: rtl/mul_ternary_param.sv
// Ternary x general polynomial multiplier over Z_2^COEF_W[x]/(x^N+1), one product term column per cycle.
// Define MUL_TERNARY_CYCLIC_EN to add the x^N-1 reduction selected by mode_cyclic.

module mul_ternary_lane #(
  parameter int COEF_W = 8
) (
  input  logic [1:0]        t_code,
  input  logic [COEF_W-1:0] acc,
  input  logic [COEF_W-1:0] r,
  output logic [COEF_W-1:0] acc_nxt
);
  // Reserved code 10 contributes nothing, same as 00.
  always_comb begin
    case (t_code)
      2'b01:   acc_nxt = acc + r;
      2'b11:   acc_nxt = acc - r;
      default: acc_nxt = acc;
    endcase
  end
endmodule

module mul_ternary_param #(
  parameter int PARAM_N = 512,
  parameter int COEF_W  = 8,
  parameter int ADDR_W  = $clog2(PARAM_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_write,
  input  logic              enable_calc,
  input  logic              enable_read,
  input  logic              mode_cyclic,
  input  logic [ADDR_W-1:0] addr,
  input  logic [COEF_W-1:0] wdata_gen,
  input  logic [1:0]        wdata_ter,
  output logic [COEF_W-1:0] rdata,
  output logic              ready,
  output logic              ter_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              k_q, k_d;
  logic                           ready_q, ready_d;
  logic                           ter_err_q, ter_err_d;
  logic [COEF_W-1:0]              rdata_q, rdata_d;
  logic [PARAM_N-1:0][COEF_W-1:0] acc_q, acc_d, acc_nxt;
  logic [PARAM_N-1:0][COEF_W-1:0] r_q, r_d, r_rot;
  logic [PARAM_N-1:0][COEF_W-1:0] g_q, g_d;
  logic [PARAM_N-1:0][1:0]        t_q, t_d;
  logic [1:0]                     t_k;
  logic [COEF_W-1:0]              wrap;

  assign t_k = t_q[k_q];

`ifdef MUL_TERNARY_CYCLIC_EN
  logic mode_q, mode_d;
  assign wrap = mode_q ? r_q[PARAM_N-1] : -r_q[PARAM_N-1];
`else
  logic unused_mode;
  assign unused_mode = mode_cyclic;
  assign wrap        = -r_q[PARAM_N-1];
`endif

  // r walks one position up each cycle; the top element re-enters at 0 (negated for x^N+1).
  assign r_rot[0] = wrap;
  for (genvar j = 0; j < PARAM_N; j++) begin : g_lane
    if (j > 0) begin : g_shift
      assign r_rot[j] = r_q[j-1];
    end
    mul_ternary_lane #(.COEF_W(COEF_W)) u_lane (
      .t_code (t_k),
      .acc    (acc_q[j]),
      .r      (r_q[j]),
      .acc_nxt(acc_nxt[j])
    );
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    ready_d   = ready_q;
    ter_err_d = ter_err_q;
    rdata_d   = rdata_q;
    acc_d     = acc_q;
    r_d       = r_q;
    g_d       = g_q;
    t_d       = t_q;
`ifdef MUL_TERNARY_CYCLIC_EN
    mode_d    = mode_q;
`endif
    case (state_q)
      CALC: begin
        acc_d = acc_nxt;
        r_d   = r_rot;
        if (t_k == 2'b10) ter_err_d = 1'b1;
        if (k_q == ADDR_W'(PARAM_N - 1)) begin
          state_d = DONE;
          ready_d = 1'b1;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: begin
        if (enable_calc) begin
          state_d   = CALC;
          acc_d     = '0;
          r_d       = g_q;
          ready_d   = 1'b0;
          ter_err_d = 1'b0;
          k_d       = '0;
`ifdef MUL_TERNARY_CYCLIC_EN
          mode_d    = mode_cyclic;
`endif
        end else if (enable_write) begin
          g_d[addr] = wdata_gen;
          t_d[addr] = wdata_ter;
        end
        if (enable_read) rdata_d = acc_q[addr];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      ready_q   <= 1'b0;
      ter_err_q <= 1'b0;
      rdata_q   <= '0;
      acc_q     <= '0;
      r_q       <= '0;
      g_q       <= '0;
      t_q       <= '0;
`ifdef MUL_TERNARY_CYCLIC_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ready_q   <= ready_d;
      ter_err_q <= ter_err_d;
      rdata_q   <= rdata_d;
      acc_q     <= acc_d;
      r_q       <= r_d;
      g_q       <= g_d;
      t_q       <= t_d;
`ifdef MUL_TERNARY_CYCLIC_EN
      mode_q    <= mode_d;
`endif
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign ter_err = ter_err_q;
endmodule

// File: tb/tb_mul_ternary_param.sv
// Directed bench for mul_ternary_param: N=4 scenarios plus an N=512 product against a convolution model.
module tb_mul_ternary_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_w = 1'b0, en_c = 1'b0, en_r = 1'b0, mode = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] wgen = '0;
  logic [1:0] wter = '0;
  logic [7:0] rdata;
  logic       ready, ter_err;

  logic       b_en_w = 1'b0, b_en_c = 1'b0, b_en_r = 1'b0, b_mode = 1'b0;
  logic [8:0] b_addr = '0;
  logic [7:0] b_wgen = '0;
  logic [1:0] b_wter = '0;
  logic [7:0] b_rdata;
  logic       b_ready, b_ter_err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mul_ternary_param #(.PARAM_N(4), .COEF_W(8)) dut (
    .clk(clk), .rst(rst), .enable_write(en_w), .enable_calc(en_c), .enable_read(en_r),
    .mode_cyclic(mode), .addr(addr), .wdata_gen(wgen), .wdata_ter(wter),
    .rdata(rdata), .ready(ready), .ter_err(ter_err)
  );

  mul_ternary_param #(.PARAM_N(512), .COEF_W(8)) dut_big (
    .clk(clk), .rst(rst), .enable_write(b_en_w), .enable_calc(b_en_c), .enable_read(b_en_r),
    .mode_cyclic(b_mode), .addr(b_addr), .wdata_gen(b_wgen), .wdata_ter(b_wter),
    .rdata(b_rdata), .ready(b_ready), .ter_err(b_ter_err)
  );

  task automatic do_write(input int a, input logic [7:0] gv, input logic [1:0] tv);
    @(negedge clk); en_w = 1'b1; addr = 2'(a); wgen = gv; wter = tv;
    @(negedge clk); en_w = 1'b0;
  endtask

  task automatic do_read(input int a, output logic [7:0] v);
    @(negedge clk); en_r = 1'b1; addr = 2'(a);
    @(negedge clk); en_r = 1'b0; v = rdata;
  endtask

  // cyc counts negedges from the one where enable_calc is raised; mode flips after the start edge.
  task automatic run_calc(input logic m, output int cyc);
    @(negedge clk); en_c = 1'b1; mode = m; cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin en_c = 1'b0; mode = ~m; end
    end while (!ready && cyc < 200);
  endtask

  task automatic test_reset;
    logic [7:0] v;
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%0b exp=0", ready); end
    checks++; if (rdata !== 8'd0) begin fails++; $display("FAIL reset_rdata got=%0d exp=0", rdata); end
    checks++; if (ter_err !== 1'b0) begin fails++; $display("FAIL reset_ter_err got=%0b exp=0", ter_err); end
    do_read(2, v);
    checks++; if (v !== 8'd0) begin fails++; $display("FAIL reset_acc2 got=%0d exp=0", v); end
  endtask

  task automatic test_negacyclic;
    int cyc; logic [7:0] v; logic [7:0] exp [4];
    exp[0] = 8'd252; exp[1] = 8'd1; exp[2] = 8'd2; exp[3] = 8'd3;
    for (int i = 0; i < 4; i++) do_write(i, 8'(i + 1), (i == 1) ? 2'b01 : 2'b00);
    run_calc(1'b0, cyc);
    checks++; if (cyc !== 5) begin fails++; $display("FAIL neg_latency got=%0d exp=5", cyc); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL neg_ready got=%0b exp=1", ready); end
    for (int i = 0; i < 4; i++) begin
      do_read(i, v);
      checks++; if (v !== exp[i]) begin fails++; $display("FAIL neg_coef%0d got=%0d exp=%0d", i, v, exp[i]); end
    end
  endtask

  task automatic test_cyclic;
    int cyc; logic [7:0] v; logic [7:0] exp [4];
`ifdef MUL_TERNARY_CYCLIC_EN
    exp[0] = 8'd4;
`else
    exp[0] = 8'd252;
`endif
    exp[1] = 8'd1; exp[2] = 8'd2; exp[3] = 8'd3;
    run_calc(1'b1, cyc);
    for (int i = 0; i < 4; i++) begin
      do_read(i, v);
      checks++; if (v !== exp[i]) begin fails++; $display("FAIL cyc_coef%0d got=%0d exp=%0d", i, v, exp[i]); end
    end
  endtask

  // Write and read issued mid-calculation must change nothing.
  task automatic test_calc_ignores_io;
    int cyc; logic [7:0] v; logic [7:0] exp [4];
    exp[0] = 8'd252; exp[1] = 8'd1; exp[2] = 8'd2; exp[3] = 8'd3;
    @(negedge clk); en_c = 1'b1; mode = 1'b0;
    @(negedge clk); en_c = 1'b0; en_w = 1'b1; en_r = 1'b1; addr = 2'd0; wgen = 8'd99; wter = 2'b01;
    @(negedge clk); en_w = 1'b0; en_r = 1'b0;
    checks++; if (rdata !== 8'd3) begin fails++; $display("FAIL calc_rdata_hold got=%0d exp=3", rdata); end
    cyc = 0;
    while (!ready && cyc < 200) begin @(negedge clk); cyc++; end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL calc_io_ready got=%0b exp=1", ready); end
    for (int i = 0; i < 4; i++) begin
      do_read(i, v);
      checks++; if (v !== exp[i]) begin fails++; $display("FAIL calc_io_coef%0d got=%0d exp=%0d", i, v, exp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int cyc; logic [7:0] v; logic [7:0] exp [4];
    exp[0] = 8'd255; exp[1] = 8'd254; exp[2] = 8'd253; exp[3] = 8'd252;
    do_write(0, 8'd1, 2'b11);
    do_write(1, 8'd2, 2'b00);
    for (int pass = 0; pass < 2; pass++) begin
      run_calc(1'b0, cyc);
      checks++; if (cyc !== 5) begin fails++; $display("FAIL b2b_latency pass=%0d got=%0d exp=5", pass, cyc); end
      for (int i = 0; i < 4; i++) begin
        do_read(i, v);
        checks++; if (v !== exp[i]) begin fails++; $display("FAIL b2b_coef%0d pass=%0d got=%0d exp=%0d", i, pass, v, exp[i]); end
      end
    end
  endtask

  task automatic test_ter_err;
    int cyc; logic [7:0] v;
    do_write(0, 8'd1, 2'b00);
    do_write(2, 8'd3, 2'b10);
    run_calc(1'b0, cyc);
    checks++; if (ter_err !== 1'b1) begin fails++; $display("FAIL ter_err_set got=%0b exp=1", ter_err); end
    for (int i = 0; i < 4; i++) begin
      do_read(i, v);
      checks++; if (v !== 8'd0) begin fails++; $display("FAIL ter_coef%0d got=%0d exp=0", i, v); end
    end
    @(negedge clk); en_c = 1'b1;
    @(negedge clk); en_c = 1'b0;
    checks++; if (ter_err !== 1'b0) begin fails++; $display("FAIL ter_err_clear got=%0b exp=0", ter_err); end
    cyc = 0;
    while (!ready && cyc < 200) begin @(negedge clk); cyc++; end
    checks++; if (ter_err !== 1'b1) begin fails++; $display("FAIL ter_err_reset got=%0b exp=1", ter_err); end
  endtask

  task automatic test_reset_abort;
    int cyc; logic [7:0] v;
    do_write(2, 8'd3, 2'b00);
    do_write(1, 8'd2, 2'b01);
    run_calc(1'b0, cyc);
    do_read(1, v);
    checks++; if (v !== 8'd1) begin fails++; $display("FAIL abort_pre_read got=%0d exp=1", v); end
    @(negedge clk); en_c = 1'b1;
    @(negedge clk); en_c = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL abort_ready got=%0b exp=0", ready); end
    checks++; if (rdata !== 8'd0) begin fails++; $display("FAIL abort_rdata got=%0d exp=0", rdata); end
    checks++; if (ter_err !== 1'b0) begin fails++; $display("FAIL abort_ter_err got=%0b exp=0", ter_err); end
    @(negedge clk); rst = 1'b1;
    do_read(0, v);
    checks++; if (v !== 8'd0) begin fails++; $display("FAIL abort_acc0 got=%0d exp=0", v); end
    do_read(1, v);
    checks++; if (v !== 8'd0) begin fails++; $display("FAIL abort_acc1 got=%0d exp=0", v); end
  endtask

  // t[0]=+1 with g[0]=100 would land if the write slipped through.
  task automatic test_write_vs_calc;
    int cyc; logic [7:0] v; logic [7:0] exp [4];
    exp[0] = 8'd252; exp[1] = 8'd1; exp[2] = 8'd2; exp[3] = 8'd3;
    for (int i = 0; i < 4; i++) do_write(i, 8'(i + 1), (i == 1) ? 2'b01 : 2'b00);
    @(negedge clk); en_c = 1'b1; en_w = 1'b1; addr = 2'd0; wgen = 8'd100; wter = 2'b01; mode = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin en_c = 1'b0; en_w = 1'b0; end
    end while (!ready && cyc < 200);
    checks++; if (cyc !== 5) begin fails++; $display("FAIL wvc_latency got=%0d exp=5", cyc); end
    for (int i = 0; i < 4; i++) begin
      do_read(i, v);
      checks++; if (v !== exp[i]) begin fails++; $display("FAIL wvc_coef%0d got=%0d exp=%0d", i, v, exp[i]); end
    end
  endtask

  task automatic test_big;
    logic [7:0] g [512]; logic [1:0] t [512]; logic [7:0] exp [512];
    int cyc, sum, s, nbad;
    for (int i = 0; i < 512; i++) begin
      g[i] = 8'(i * 37 + 5);
      t[i] = (i % 7 == 0) ? 2'b01 : ((i % 11 == 3) ? 2'b11 : 2'b00);
    end
    // c[j] = sum_k t[k]*g[j-k], with wrapped terms negated for x^N+1.
    for (int j = 0; j < 512; j++) begin
      sum = 0;
      for (int k = 0; k < 512; k++) begin
        s = (t[k] == 2'b01) ? 1 : ((t[k] == 2'b11) ? -1 : 0);
        if (j >= k) sum += s * int'(g[j-k]);
        else        sum -= s * int'(g[j-k+512]);
      end
      exp[j] = 8'(sum);
    end
    for (int i = 0; i < 512; i++) begin
      @(negedge clk); b_en_w = 1'b1; b_addr = 9'(i); b_wgen = g[i]; b_wter = t[i];
    end
    @(negedge clk); b_en_w = 1'b0; b_en_c = 1'b1; b_mode = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1) b_en_c = 1'b0;
    end while (!b_ready && cyc < 2000);
    checks++; if (cyc !== 513) begin fails++; $display("FAIL big_latency got=%0d exp=513", cyc); end
    nbad = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk); b_en_r = 1'b1; b_addr = 9'(i);
      @(negedge clk); b_en_r = 1'b0;
      checks++;
      if (b_rdata !== exp[i]) begin
        fails++; nbad++;
        if (nbad <= 8) $display("FAIL big_coef%0d got=%0d exp=%0d", i, b_rdata, exp[i]);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset;
    test_negacyclic;
    test_cyclic;
    test_calc_ignores_io;
    test_back_to_back;
    test_ter_err;
    test_reset_abort;
    test_write_vs_calc;
    test_big;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
